// File: rtl/arm_isa_pkg.sv
// Shared ARM-format instruction field layout and op classes, used by the
// encoder and by the decoder in the control path.
package arm_isa_pkg;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_MSB    = 27;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 25;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RN_MSB    = 19;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned SRC2_MSB  = 11;
  localparam int unsigned SRC2_LSB  = 0;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone,
    StError
  } enc_state_e;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: places each instruction field at its ARM-format bit
// position without modifying any field.
module instr_word_pack
  import arm_isa_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[COND_MSB:COND_LSB]   = cond;
    word[OP_MSB:OP_LSB]       = op;
    word[FUNCT_MSB:FUNCT_LSB] = funct;
    word[RN_MSB:RN_LSB]       = rn;
    word[RD_MSB:RD_LSB]       = rd;
    word[SRC2_MSB:SRC2_LSB]   = src2;
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: accepts instruction field sets on a valid/ready stream, packs
// them and writes them to imem, holding the core in reset until the load ends.
module instr_stream_encoder
  import arm_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MaxCount = (ADDR_W + 1)'(MAX_WORDS);

  enc_state_e  state;
  logic        weQ;
  logic        lastQ;
  logic [31:0] packedWord;

  instr_word_pack uPack (
    .cond  (in_cond),
    .op    (in_op),
    .funct (in_funct),
    .rn    (in_rn),
    .rd    (in_rd),
    .src2  (in_src2),
    .word  (packedWord)
  );

  // Reset is sampled synchronously, so gate the strobe to kill a write that
  // would otherwise land in the same cycle reset is asserted.
  assign imem_we = weQ & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      in_ready   <= 1'b0;
      weQ        <= 1'b0;
      lastQ      <= 1'b0;
      imem_addr  <= BaseAddr;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;
      weQ  <= 1'b0;
      unique case (state)
        StIdle, StDone, StError: begin
          if (start) begin
            state      <= StLoad;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            error      <= 1'b0;
            word_count <= '0;
            imem_addr  <= BaseAddr;
          end else if (state == StDone) begin
            state <= StIdle;
          end
        end
        StLoad: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            // Rejected transfers are consumed without a write.
            if (in_op == OP_UNDEF || word_count == MaxCount) begin
              state <= StError;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= StWrite;
              weQ        <= 1'b1;
              imem_wdata <= packedWord;
              lastQ      <= in_last;
            end
          end
        end
        StWrite: begin
          word_count <= word_count + 1'b1;
          imem_addr  <= imem_addr + 1'b1;
          if (lastQ) begin
            state    <= StDone;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end else begin
            state    <= StLoad;
            in_ready <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench: two encoder instances (base 0 / max 4, base 62 / max 64)
// share one stimulus stream; writes are logged and compared with a session model.
module tb_instr_stream_encoder;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic        last;
    int          gap;
  } item_t;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [31:0] expWord;
  } vec_t;

  logic clk, rst_n, start, inValid, inLast;
  logic [3:0] inCond, inRn, inRd;
  logic [1:0] inOp;
  logic [5:0] inFunct;
  logic [11:0] inSrc2;

  logic rdyA, weA, holdA, busyA, doneA, errA;
  logic rdyB, weB, holdB, busyB, doneB, errB;
  logic [5:0] addrA, addrB;
  logic [31:0] wdataA, wdataB;
  logic [6:0] cntA, cntB;

  int nChecks, nPass, cyc, lastWeCycA, doneCntA, doneCntB;
  logic [37:0] logA[$], logB[$], expWr[$];
  item_t items[$];

  instr_stream_encoder #(.ADDR_W(6), .BASE_ADDR(0), .MAX_WORDS(4)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid), .in_ready(rdyA),
    .in_cond(inCond), .in_op(inOp), .in_funct(inFunct), .in_rn(inRn), .in_rd(inRd),
    .in_src2(inSrc2), .in_last(inLast), .imem_we(weA), .imem_addr(addrA),
    .imem_wdata(wdataA), .cpu_hold(holdA), .busy(busyA), .done(doneA), .error(errA),
    .word_count(cntA)
  );

  instr_stream_encoder #(.ADDR_W(6), .BASE_ADDR(62), .MAX_WORDS(64)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid), .in_ready(rdyB),
    .in_cond(inCond), .in_op(inOp), .in_funct(inFunct), .in_rn(inRn), .in_rd(inRd),
    .in_src2(inSrc2), .in_last(inLast), .imem_we(weB), .imem_addr(addrB),
    .imem_wdata(wdataB), .cpu_hold(holdB), .busy(busyB), .done(doneB), .error(errB),
    .word_count(cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Committed writes and done pulses, observed at the edge that commits them.
  always @(posedge clk) begin
    if (weA) begin
      logA.push_back({addrA, wdataA});
      chk("in_ready low during write", 64'(rdyA), 64'd0);
      lastWeCycA = cyc;
    end
    if (weB) logB.push_back({addrB, wdataB});
    if (doneA) begin
      doneCntA++;
      chk("done right after final write", 64'(lastWeCycA), 64'(cyc - 1));
    end
    if (doneB) doneCntB++;
    cyc++;
  end

  function automatic logic [31:0] wordOf(input item_t it);
    return 32'(it.cond) * 32'h1000_0000 + 32'(it.op) * 32'h0400_0000 +
           32'(it.funct) * 32'h0010_0000 + 32'(it.rn) * 32'h0001_0000 +
           32'(it.rd) * 32'h0000_1000 + 32'(it.src2);
  endfunction

  // Session outcome from the loader's rules: each accepted item either aborts the
  // session (undefined op, or already full) or is written at base+count mod 64.
  task automatic runModel(input int base, input int maxw, output int cnt, output bit err,
                          output bit dn);
    expWr.delete();
    cnt = 0; err = 0; dn = 0;
    foreach (items[i]) begin
      if (items[i].op == 2'b11 || cnt == maxw) begin
        err = 1;
        break;
      end
      expWr.push_back({6'((base + cnt) % 64), wordOf(items[i])});
      cnt++;
      if (items[i].last) begin
        dn = 1;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 0; start = 0; inValid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    logA.delete(); logB.delete();
    doneCntA = 0; doneCntB = 0;
  endtask

  task automatic pulseStart();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic drive(input item_t it);
    inCond = it.cond; inOp = it.op; inFunct = it.funct; inRn = it.rn;
    inRd = it.rd; inSrc2 = it.src2; inLast = it.last;
  endtask

  task automatic send(input item_t it);
    int n;
    repeat (it.gap) @(negedge clk);
    drive(it);
    inValid = 1;
    n = 0;
    while (!rdyB && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("handshake timeout", 64'd1, 64'd0);
    else @(negedge clk);
    inValid = 0;
  endtask

  task automatic checkInst(input bit isB, input string tag);
    int cnt, nw, actN, actCnt, actDone;
    bit err, dn, actErr, actHold, actBusy;
    logic [37:0] got;
    if (isB) runModel(62, 64, cnt, err, dn);
    else runModel(0, 4, cnt, err, dn);
    actN    = isB ? logB.size() : logA.size();
    actCnt  = isB ? int'(cntB) : int'(cntA);
    actErr  = isB ? errB : errA;
    actHold = isB ? holdB : holdA;
    actBusy = isB ? busyB : busyA;
    actDone = isB ? doneCntB : doneCntA;
    chk({tag, " write count"}, 64'(actN), 64'(expWr.size()));
    nw = (actN < expWr.size()) ? actN : expWr.size();
    for (int i = 0; i < nw; i++) begin
      got = isB ? logB[i] : logA[i];
      chk($sformatf("%s write %0d addr/data", tag, i), 64'(got), 64'(expWr[i]));
    end
    chk({tag, " word_count"}, 64'(actCnt), 64'(cnt));
    chk({tag, " error"}, 64'(actErr), 64'(err));
    chk({tag, " done pulses"}, 64'(actDone), 64'(dn));
    chk({tag, " cpu_hold"}, 64'(actHold), 64'(!dn));
    chk({tag, " busy"}, 64'(actBusy), 64'(!dn && !err));
  endtask

  task automatic runSession(input string tag);
    doReset();
    pulseStart();
    foreach (items[i]) begin
      send(items[i]);
      if (items[i].last || items[i].op == 2'b11) break;
    end
    repeat (4) @(negedge clk);
    checkInst(0, {tag, " A"});
    checkInst(1, {tag, " B"});
  endtask

  function automatic item_t mk(input logic [1:0] op, input logic last, input int gap);
    item_t it;
    it.cond = 4'($urandom); it.op = op; it.funct = 6'($urandom);
    it.rn = 4'($urandom); it.rd = 4'($urandom); it.src2 = 12'($urandom);
    it.last = last; it.gap = gap;
    return it;
  endfunction

  vec_t vecs[5];

  initial begin
    item_t it;
    int len;
    nChecks = 0; nPass = 0; cyc = 0; lastWeCycA = -10;
    rst_n = 0; start = 0; inValid = 0; inLast = 0;
    inCond = 0; inOp = 0; inFunct = 0; inRn = 0; inRd = 0; inSrc2 = 0;

    vecs[0] = '{4'hE, 2'b00, 6'h08, 4'h1, 4'h2, 12'h005, 32'hE081_2005};
    vecs[1] = '{4'h0, 2'b01, 6'h19, 4'hF, 4'h3, 12'hABC, 32'h059F_3ABC};
    vecs[2] = '{4'hA, 2'b10, 6'h3F, 4'h0, 4'h0, 12'h000, 32'hABF0_0000};
    vecs[3] = '{4'h1, 2'b00, 6'h00, 4'h0, 4'h0, 12'hFFF, 32'h1000_0FFF};
    vecs[4] = '{4'hF, 2'b01, 6'h2A, 4'h7, 4'h8, 12'h123, 32'hF6A7_8123};

    doReset();
    chk("reset in_ready", 64'(rdyA), 64'd0);
    chk("reset imem_we", 64'(weA), 64'd0);
    chk("reset addr A", 64'(addrA), 64'd0);
    chk("reset addr B", 64'(addrB), 64'd62);
    chk("reset wdata", 64'(wdataA), 64'd0);
    chk("reset cpu_hold", 64'(holdA), 64'd1);
    chk("reset busy/done/error", 64'({busyA, doneA, errA}), 64'd0);
    chk("reset word_count", 64'(cntA), 64'd0);

    // Single word, cycle by cycle.
    pulseStart();
    chk("load in_ready", 64'(rdyA), 64'd1);
    chk("load busy", 64'(busyA), 64'd1);
    it = '{4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 12'h005, 1'b1, 0};
    drive(it);
    inValid = 1;
    @(negedge clk);
    inValid = 0;
    chk("write strobe", 64'(weA), 64'd1);
    chk("write addr", 64'(addrA), 64'd0);
    chk("write data", 64'(wdataA), 64'hE081_2005);
    @(negedge clk);
    chk("done pulse", 64'(doneA), 64'd1);
    chk("done strobe off", 64'(weA), 64'd0);
    chk("done cpu_hold", 64'(holdA), 64'd0);
    chk("done word_count", 64'(cntA), 64'd1);
    @(negedge clk);
    chk("done one cycle", 64'(doneA), 64'd0);
    chk("idle cpu_hold", 64'(holdA), 64'd0);

    foreach (vecs[i]) begin
      items.delete();
      items.push_back('{vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rn, vecs[i].rd,
                        vecs[i].src2, 1'b1, 1});
      runSession($sformatf("vec%0d", i));
      chk($sformatf("vec%0d packed word", i), 64'(wdataA), 64'(vecs[i].expWord));
    end

    items.delete();
    for (int i = 0; i < 3; i++) items.push_back(mk(2'(i % 3), i == 2, 2));
    runSession("gapped3");

    items.delete();
    items.push_back(mk(2'b01, 0, 0));
    items.push_back(mk(2'b11, 0, 0));
    runSession("undef2");
    chk("undef in_ready", 64'(rdyA), 64'd0);
    pulseStart();
    chk("restart clears error", 64'(errA), 64'd0);
    chk("restart in_ready", 64'(rdyA), 64'd1);

    items.delete();
    for (int i = 0; i < 5; i++) items.push_back(mk(2'b00, 0, 1));
    runSession("overflow");

    items.delete();
    for (int i = 0; i < 4; i++) items.push_back(mk(2'b10, i == 3, 0));
    runSession("full4");

    items.delete();
    for (int i = 0; i < 3; i++) items.push_back(mk(2'b00, i == 2, 0));
    runSession("wrap");

    // Reset asserted while the write strobe is up.
    doReset();
    pulseStart();
    drive(mk(2'b00, 1, 0));
    inValid = 1;
    @(negedge clk);
    inValid = 0;
    chk("pre-reset strobe", 64'(weA), 64'd1);
    rst_n = 0;
    #1;
    chk("strobe gated by reset", 64'(weA), 64'd0);
    @(negedge clk);
    rst_n = 1;
    chk("no write committed", 64'(logA.size()), 64'd0);
    chk("mid reset cpu_hold", 64'(holdA), 64'd1);
    chk("mid reset in_ready/busy/done", 64'({rdyA, busyA, doneA, errA}), 64'd0);
    chk("mid reset addr/count/data", 64'({addrA, cntA, wdataA}), 64'd0);

    for (int s = 0; s < 25; s++) begin
      items.delete();
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        it = mk(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                i == len - 1, $urandom_range(0, 3));
        items.push_back(it);
      end
      runSession($sformatf("rand%0d", s));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
